// File: rtl/bcd_counter_n.sv
// Multi-digit BCD up/down counter with decade divider output.
// Raises tc for one cycle on wrap and toggles div_out.
module bcd_counter_n #(
  parameter int DIGITS = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              up_dn,
  input  logic              clr,
  input  logic              load,
  input  logic [4*DIGITS-1:0] load_val,
  output logic [4*DIGITS-1:0] count,
  output logic              tc,
  output logic              div_out
);

  localparam int W = 4*DIGITS;

  logic [W-1:0] cnt_nxt;
  logic [W-1:0] ld_clamp;
  logic         carry;
  logic         wrap;
  logic [3:0]   dig;
  logic [3:0]   nib;

  // carry doubles as borrow when counting down
  always_comb begin
    cnt_nxt  = count;
    ld_clamp = '0;
    carry    = 1'b1;
    dig      = '0;
    nib      = '0;
    for (int i = 0; i < DIGITS; i++) begin
      nib = load_val[4*i +: 4];
      ld_clamp[4*i +: 4] = (nib > 4'd9) ? 4'd9 : nib;
      dig = count[4*i +: 4];
      if (carry) begin
        if (up_dn) begin
          if (dig == 4'd9) begin
            cnt_nxt[4*i +: 4] = 4'd0;
          end else begin
            cnt_nxt[4*i +: 4] = dig + 4'd1;
            carry = 1'b0;
          end
        end else begin
          if (dig == 4'd0) begin
            cnt_nxt[4*i +: 4] = 4'd9;
          end else begin
            cnt_nxt[4*i +: 4] = dig - 4'd1;
            carry = 1'b0;
          end
        end
      end
    end
    wrap = carry;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count   <= '0;
      tc      <= 1'b0;
      div_out <= 1'b0;
    end else if (clr) begin
      count <= '0;
      tc    <= 1'b0;
    end else if (load) begin
      count <= ld_clamp;
      tc    <= 1'b0;
    end else if (en) begin
      count <= cnt_nxt;
      tc    <= wrap;
      if (wrap) div_out <= ~div_out;
    end else begin
      tc <= 1'b0;
    end
  end

endmodule

// File: tb/tb_bcd_counter_n.sv
// Directed self-checking bench for bcd_counter_n.
// Exercises a 2-digit and a 1-digit instance.
module tb_bcd_counter_n;

  logic       clk = 1'b0;
  logic       rst;
  logic       en, up_dn, clr, load;
  logic [7:0] load_val;
  logic [7:0] count;
  logic       tc, div_out;

  logic       en1, up_dn1, clr1, load1;
  logic [3:0] load_val1;
  logic [3:0] count1;
  logic       tc1, div_out1;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  bcd_counter_n #(.DIGITS(2)) u2 (
    .clk(clk), .rst(rst), .en(en), .up_dn(up_dn),
    .clr(clr), .load(load), .load_val(load_val),
    .count(count), .tc(tc), .div_out(div_out)
  );

  bcd_counter_n #(.DIGITS(1)) u1 (
    .clk(clk), .rst(rst), .en(en1), .up_dn(up_dn1),
    .clr(clr1), .load(load1), .load_val(load_val1),
    .count(count1), .tc(tc1), .div_out(div_out1)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  int tc_hits;
  logic [3:0] m_cnt;
  logic       m_tc, m_div;

  initial begin
    rst = 1'b0; en = 1'b0; up_dn = 1'b1; clr = 1'b0; load = 1'b0;
    load_val = '0;
    en1 = 1'b0; up_dn1 = 1'b1; clr1 = 1'b0; load1 = 1'b0;
    load_val1 = '0;
    #12;
    chk("rst_count", count, 8'h00);
    chk("rst_tc", tc, 1'b0);
    chk("rst_div", div_out, 1'b0);
    chk("rst_count1", count1, 4'h0);
    @(negedge clk);
    rst = 1'b1;
    tick(1);

    // reset mid-count
    en = 1'b1; up_dn = 1'b1;
    tick(37);
    chk("pre_rst_37", count, 8'h37);
    #2;
    rst = 1'b0;
    #1;
    chk("async_rst_count", count, 8'h00);
    chk("async_rst_tc", tc, 1'b0);
    chk("async_rst_div", div_out, 1'b0);
    rst = 1'b1;
    tick(5);
    chk("post_rst_5", count, 8'h05);

    // up wrap and divisor period
    clr = 1'b1;
    tick(1);
    clr = 1'b0;
    chk("clr_zero", count, 8'h00);
    tick(99);
    chk("up_99", count, 8'h99);
    chk("up_99_tc", tc, 1'b0);
    chk("up_99_div", div_out, 1'b0);
    tick(1);
    chk("upwrap_count", count, 8'h00);
    chk("upwrap_tc", tc, 1'b1);
    chk("upwrap_div", div_out, 1'b1);
    tick(1);
    chk("upwrap_tc_drop", tc, 1'b0);
    chk("upwrap_next", count, 8'h01);
    tc_hits = 0;
    for (int i = 0; i < 98; i++) begin
      tick(1);
      if (tc) tc_hits++;
    end
    chk("no_extra_tc", tc_hits, 0);
    chk("up_199_div", div_out, 1'b1);
    tick(1);
    chk("up_200_count", count, 8'h00);
    chk("up_200_tc", tc, 1'b1);
    chk("up_200_div", div_out, 1'b0);

    // down wrap and direction change
    en = 1'b0; load = 1'b1; load_val = 8'h01;
    tick(1);
    chk("load_01", count, 8'h01);
    chk("load_tc", tc, 1'b0);
    load = 1'b0; en = 1'b1; up_dn = 1'b0;
    tick(1);
    chk("dn_00", count, 8'h00);
    chk("dn_00_tc", tc, 1'b0);
    tick(1);
    chk("dnwrap_count", count, 8'h99);
    chk("dnwrap_tc", tc, 1'b1);
    chk("dnwrap_div", div_out, 1'b1);
    up_dn = 1'b1;
    tick(1);
    chk("dir_up_count", count, 8'h00);
    chk("dir_up_tc", tc, 1'b1);
    chk("dir_up_div", div_out, 1'b0);
    up_dn = 1'b0;
    load = 1'b1; load_val = 8'h50;
    tick(1);
    load = 1'b0;
    tick(1);
    chk("borrow_49", count, 8'h49);

    // load clamp and priority
    en = 1'b0; load = 1'b1; load_val = 8'hA3;
    tick(1);
    chk("clamp_hi", count, 8'h93);
    load_val = 8'h7F;
    tick(1);
    chk("clamp_lo", count, 8'h79);
    clr = 1'b1;
    tick(1);
    chk("clr_over_load", count, 8'h00);
    clr = 1'b0; en = 1'b1; up_dn = 1'b1; load_val = 8'h42;
    tick(1);
    chk("load_over_en", count, 8'h42);
    chk("load_over_en_tc", tc, 1'b0);

    // hold and boundary blocking
    load_val = 8'h99;
    tick(1);
    load = 1'b0; en = 1'b0;
    tick(10);
    chk("hold_count", count, 8'h99);
    chk("hold_tc", tc, 1'b0);
    chk("hold_div", div_out, 1'b0);
    clr = 1'b1; en = 1'b1;
    tick(1);
    clr = 1'b0;
    chk("clr_block_count", count, 8'h00);
    chk("clr_block_tc", tc, 1'b0);
    chk("clr_block_div", div_out, 1'b0);
    load = 1'b1; load_val = 8'h99;
    tick(1);
    tick(1);
    chk("load_block_count", count, 8'h99);
    chk("load_block_tc", tc, 1'b0);
    chk("load_block_div", div_out, 1'b0);
    load = 1'b0;
    tick(1);
    chk("wrap_again_tc", tc, 1'b1);
    chk("wrap_again_div", div_out, 1'b1);
    en = 1'b0;
    tick(1);
    chk("en_low_tc_fall", tc, 1'b0);
    chk("en_low_div_hold", div_out, 1'b1);
    chk("en_low_count", count, 8'h00);

    // reset while tc high
    load = 1'b1; load_val = 8'h99;
    tick(1);
    load = 1'b0; en = 1'b1;
    tick(1);
    chk("pre_rst_tc", tc, 1'b1);
    #2;
    rst = 1'b0;
    #1;
    chk("rst_tc_drop", tc, 1'b0);
    chk("rst_div_clear", div_out, 1'b0);
    en = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    tick(1);

    // single-digit regression: divide-by-20
    en1 = 1'b1; up_dn1 = 1'b1;
    m_cnt = 4'd0; m_div = 1'b0;
    for (int i = 1; i <= 40; i++) begin
      tick(1);
      m_cnt = (m_cnt == 4'd9) ? 4'd0 : m_cnt + 4'd1;
      m_tc  = (i % 10 == 0);
      if (m_tc) m_div = ~m_div;
      chk($sformatf("d1_count_%0d", i), count1, m_cnt);
      chk($sformatf("d1_tc_%0d", i), tc1, m_tc);
      chk($sformatf("d1_div_%0d", i), div_out1, m_div);
    end
    chk("d1_div_after_20", div_out1, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/bcd_counter_n.md
# bcd_counter_n

Parametrised multi-digit BCD counter and decade clock divider. It counts up or down across DIGITS cascaded decimal digits, with enable, synchronous clear and parallel load. It produces a one-cycle terminal-count pulse and a divided-clock output that toggles on every wrap. It serves as the general-purpose successor to the single-digit divide-by-10 counter, for timebases, display counters and programmable decade dividers.

## Interface
- DIGITS, 2, number of BCD digits; legal range 1..8; count width is 4*DIGITS

- clk  input  1  rising-edge clock; all state updates on this edge
- rst  input  1  asynchronous, active-low reset
- en  input  1  count enable; advances count by one on a rising edge when high
- up_dn  input  1  direction: 1 = up, 0 = down; sampled on each enabled edge
- clr  input  1  synchronous clear to zero; highest synchronous priority
- load  input  1  synchronous parallel load of load_val
- load_val  input  4*DIGITS  BCD load value; nibble i is digit i, with nibble 0 as the least-significant digit
- count  output  4*DIGITS  current BCD count; nibble 0 is the least-significant digit
- tc  output  1  terminal-count pulse; high for one cycle after a wrap
- div_out  output  1  divided clock; toggles on every wrap

## Operation
- Synchronous priority on each rising clk edge: clr > load > en. Nothing changes when all three are low.
- clr: count <= 0; tc <= 0; div_out holds.
- load: each nibble of load_val is loaded into the matching digit. A nibble greater than 9 is clamped to 9. tc <= 0; div_out holds.
- en with up_dn=1:
  - Digit 0 increments.
  - A digit at 9 rolls to 0 and carries into the next digit.
  - A digit increments only if all lower digits are 9.
- en with up_dn=0:
  - Digit 0 decrements.
  - A digit at 0 rolls to 9 and borrows from the next digit.
  - A digit decrements only if all lower digits are 0.
- Wrap conditions:
  - Up wrap: all digits are 9 and an up-count occurs; count becomes all 0.
  - Down wrap: all digits are 0 and a down-count occurs; count becomes all 9.
- On a wrap: tc <= 1 and div_out <= ~div_out. On any other edge: tc <= 0.
- Divisor: with a fixed direction and en held high, div_out period is 2*10^DIGITS clocks. DIGITS=1, up-counting reproduces the divide-by-20 toggle of the legacy single-digit counter.
- Direction may change on any edge. The next enabled edge counts in the new direction from the current value; there is no extra wrap.
- Count values never leave the BCD range 0..9 per digit. Because load clamps out-of-range nibbles, no illegal state is reachable.

## Timing
- Reset: rst low immediately forces count=0, tc=0 and div_out=0, independent of clk. Reset may assert mid-count or while tc is high; tc drops at once.
- Reset release: the first rising edge with rst high performs normal operation.
- All outputs are registered; there is no combinational path from any input to any output.
- Latency:
  - load_val appears on count 1 cycle after the edge that samples load.
  - An enabled increment is visible 1 cycle after its edge.
- tc is high for exactly the one cycle in which count shows the wrapped value (all 0 up, all 9 down). div_out changes on the same edge.
- Simultaneous events:
  - clr+load: clear wins.
  - load+en: load wins and no count occurs.
  - clr or load on a would-be wrap edge: no wrap, no tc, and div_out holds.
- While en is low, count, div_out and the zero value of tc are held; tc falls on the first such edge.

## Test plan
- Reset mid-count (DIGITS=2): count=0x37, pull rst low between edges -> count=0x00, tc=0, div_out=0 immediately. Release, then 5 enabled up edges -> count=0x05.
- Up wrap (DIGITS=2): from reset, en=1, up_dn=1, 100 edges -> count=0x00 with tc=1 for one cycle and div_out=1. After 200 edges -> div_out=0, a period of 200 clocks.
- Down wrap and direction change: load 0x01, then down 2 edges -> 0x00, then 0x99 with tc=1. Then up_dn=1, 1 edge -> 0x00 with tc=1 and div_out toggled again.
- Load clamp and priority: load_val=0xA3 -> count=0x93.
  - Then load=1, clr=1 -> 0x00.
  - Then load=1, en=1, load_val=0x42 -> 0x42 with no increment.
- Hold and boundary blocking: count=0x99, en=0 for 10 edges -> count=0x99, tc=0, div_out unchanged. Then clr on the next edge with en=1 -> 0x00, tc=0, div_out unchanged.
- DIGITS=1 regression: up, en=1 -> count cycles 0..9, tc high every 10th cycle, div_out period 20 clocks.
